// File: rtl/gate_tt_checker_pkg.sv
// Shared types and defaults for the gate truth-table checker.
// The optional GATE_TT_CHECKER_STOP_ON_FAIL_EN macro is consumed in gate_tt_checker.sv.
package gate_tt_checker_pkg;

    localparam int DEF_N_IN       = 2;
    localparam int DEF_SETTLE_CYC = 1;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_DRIVE  = 3'd1,
        ST_SETTLE = 3'd2,
        ST_SAMPLE = 3'd3,
        ST_DONE   = 3'd4
    } state_e;

    // Counter width able to hold SETTLE_CYC-1; never narrower than one bit.
    function automatic int cnt_width(input int settle);
        return (settle > 1) ? $clog2(settle) : 1;
    endfunction

endpackage

// File: rtl/gate_tt_checker_if.sv
// Bundle between the checker and its environment (gate under test plus controller).
// start is a request sampled only while busy is low; done is a one-cycle completion pulse.
interface gate_tt_checker_if
    import gate_tt_checker_pkg::*;
#(
    parameter int N_IN = DEF_N_IN
);
    logic                   start;
    logic [(1<<N_IN)-1:0]   tt;
    logic [N_IN-1:0]        vec_out;
    logic                   y_in;
    logic                   busy;
    logic                   done;
    logic                   pass;
    logic [N_IN:0]          err_cnt;
    logic [N_IN-1:0]        first_fail;
    state_e                 state;

    modport master (
        output start, tt, y_in,
        input  vec_out, busy, done, pass, err_cnt, first_fail, state
    );

    modport slave (
        input  start, tt, y_in,
        output vec_out, busy, done, pass, err_cnt, first_fail, state
    );

endinterface

// File: rtl/gate_tt_settle_cnt.sv
// Loadable down-counter with a zero flag; times the settle interval after each vector.
module gate_tt_settle_cnt #(
    parameter int W = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         dec,
    output logic         zero
);
    logic [W-1:0] count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (dec && (count != '0)) begin
            count <= count - 1'b1;
        end
    end

    assign zero = (count == '0);

endmodule

// File: rtl/gate_tt_checker.sv
// Sweeps all input vectors onto a gate, samples y_in after a settle delay and scores it against tt.
// Build option: define GATE_TT_CHECKER_STOP_ON_FAIL_EN to end the sweep at the first mismatch.
module gate_tt_checker
    import gate_tt_checker_pkg::*;
#(
    parameter int N_IN       = DEF_N_IN,
    parameter int SETTLE_CYC = DEF_SETTLE_CYC
) (
    input  logic              clk,
    input  logic              rst_n,
    gate_tt_checker_if.slave  bus
);
    localparam int TT_W  = 1 << N_IN;
    localparam int CNT_W = cnt_width(SETTLE_CYC);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'((SETTLE_CYC > 0) ? SETTLE_CYC - 1 : 0);
    localparam logic [N_IN-1:0]  VEC_LAST = '1;

    state_e            state, state_nx;
    logic [TT_W-1:0]   tt_q, tt_nx;
    logic [N_IN-1:0]   vec, vec_nx;
    logic [N_IN:0]     err, err_nx;
    logic [N_IN-1:0]   ff, ff_nx;
    logic              pass_q, pass_nx;
    logic              cnt_load, cnt_dec, cnt_zero;
    logic              mismatch;

    gate_tt_settle_cnt #(.W(CNT_W)) u_settle (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (cnt_load),
        .load_val (CNT_LOAD),
        .dec      (cnt_dec),
        .zero     (cnt_zero)
    );

    assign mismatch = (bus.y_in != tt_q[vec]);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= ST_IDLE;
            tt_q   <= '0;
            vec    <= '0;
            err    <= '0;
            ff     <= '0;
            pass_q <= 1'b0;
        end else begin
            state  <= state_nx;
            tt_q   <= tt_nx;
            vec    <= vec_nx;
            err    <= err_nx;
            ff     <= ff_nx;
            pass_q <= pass_nx;
        end
    end

    always_comb begin
        state_nx = state;
        tt_nx    = tt_q;
        vec_nx   = vec;
        err_nx   = err;
        ff_nx    = ff;
        pass_nx  = pass_q;
        cnt_load = 1'b0;
        cnt_dec  = 1'b0;
        case (state)
            ST_IDLE: begin
                if (bus.start) begin
                    tt_nx    = bus.tt;
                    err_nx   = '0;
                    ff_nx    = '0;
                    pass_nx  = 1'b0;
                    vec_nx   = '0;
                    state_nx = ST_DRIVE;
                end
            end
            ST_DRIVE: begin
                if (SETTLE_CYC == 0) begin
                    state_nx = ST_SAMPLE;
                end else begin
                    cnt_load = 1'b1;
                    state_nx = ST_SETTLE;
                end
            end
            ST_SETTLE: begin
                if (cnt_zero) begin
                    state_nx = ST_SAMPLE;
                end else begin
                    cnt_dec = 1'b1;
                end
            end
            ST_SAMPLE: begin
                if (mismatch) begin
                    err_nx = err + 1'b1;
                    if (err == '0) begin
                        ff_nx = vec;
                    end
                end
`ifdef GATE_TT_CHECKER_STOP_ON_FAIL_EN
                if (mismatch || (vec == VEC_LAST)) begin
`else
                if (vec == VEC_LAST) begin
`endif
                    state_nx = ST_DONE;
                end else begin
                    vec_nx   = vec + 1'b1;
                    state_nx = ST_DRIVE;
                end
            end
            ST_DONE: begin
                // err is final here: the last SAMPLE update has already landed.
                pass_nx  = (err == '0);
                vec_nx   = '0;
                state_nx = ST_IDLE;
            end
            default: begin
                state_nx = ST_IDLE;
            end
        endcase
    end

    assign bus.vec_out    = vec;
    assign bus.busy       = (state != ST_IDLE);
    assign bus.done       = (state == ST_DONE);
    assign bus.pass       = pass_q;
    assign bus.err_cnt    = err;
    assign bus.first_fail = ff;
    assign bus.state      = state;

endmodule

// File: tb/tb_gate_tt_checker.sv
// Directed bench: two checkers (SETTLE_CYC=1 and 0) each driving an AND gate, scored cycle by cycle.
module tb_gate_tt_checker;
    logic       clk;
    logic       rst_n;
    logic       start;
    logic       sel;
    logic [3:0] tt_drv;
    int         n_checks;
    int         n_fail;
    logic [1:0] exp_q[$];

    gate_tt_checker_if #(.N_IN(2)) if0 ();
    gate_tt_checker_if #(.N_IN(2)) if1 ();

    assign if0.start = start & ~sel;
    assign if1.start = start & sel;
    assign if0.tt    = tt_drv;
    assign if1.tt    = tt_drv;
    assign if0.y_in  = &if0.vec_out;
    assign if1.y_in  = &if1.vec_out;

    gate_tt_checker #(.N_IN(2), .SETTLE_CYC(1)) dut0 (.clk(clk), .rst_n(rst_n), .bus(if0));
    gate_tt_checker #(.N_IN(2), .SETTLE_CYC(0)) dut1 (.clk(clk), .rst_n(rst_n), .bus(if1));

    logic [1:0] o_vec, o_ff;
    logic [2:0] o_err;
    logic       o_busy, o_done, o_pass;
    assign o_vec  = sel ? if1.vec_out    : if0.vec_out;
    assign o_ff   = sel ? if1.first_fail : if0.first_fail;
    assign o_err  = sel ? if1.err_cnt    : if0.err_cnt;
    assign o_busy = sel ? if1.busy       : if0.busy;
    assign o_done = sel ? if1.done       : if0.done;
    assign o_pass = sel ? if1.pass       : if0.pass;

`ifdef GATE_TT_CHECKER_STOP_ON_FAIL_EN
    localparam int OR_DONE = 6, OR_ERR = 1, NAND_DONE = 2, NAND_ERR = 1;
`else
    localparam int OR_DONE = 12, OR_ERR = 2, NAND_DONE = 8, NAND_ERR = 4;
`endif

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // One sweep: vec_out and busy scored every cycle, done timing, then results in IDLE.
    task automatic run_sweep(input string name, input logic s, input logic [3:0] tt_v,
                             input int settle, input int exp_done, input int exp_err,
                             input int exp_ff, input logic exp_pass, input int poke);
        int  c;
        int  k;
        bit  seen;
        exp_q.delete();
        k = exp_done / (settle + 2);
        for (int i = 0; i < exp_done; i++) exp_q.push_back(2'(i / (settle + 2)));
        exp_q.push_back(2'(k - 1));
        @(negedge clk);
        sel    = s;
        tt_drv = tt_v;
        start  = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        c    = 0;
        seen = 0;
        while (!seen && c <= 64) begin
            @(negedge clk);
            if (c == poke) begin
                start  = 1'b1;
                tt_drv = 4'b0000;
            end else if (c == poke + 1) begin
                start = 1'b0;
            end
            if (exp_q.size() != 0) check({name, "_vec"}, o_vec, exp_q.pop_front());
            check({name, "_busy"}, o_busy, 1);
            if (o_done) begin
                seen = 1;
                check({name, "_done_cyc"}, c, exp_done);
            end
            c++;
        end
        if (!seen) check({name, "_timeout"}, 0, 1);
        @(negedge clk);
        check({name, "_done_low"}, o_done, 0);
        check({name, "_idle"}, o_busy, 0);
        check({name, "_vec_idle"}, o_vec, 0);
        check({name, "_err"}, o_err, exp_err);
        check({name, "_ff"}, o_ff, exp_ff);
        check({name, "_pass"}, o_pass, exp_pass);
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst_n    = 1'b0;
        start    = 1'b0;
        sel      = 1'b0;
        tt_drv   = 4'b0000;
        repeat (2) @(negedge clk);
        check("rst_busy0", if0.busy, 0);
        check("rst_done0", if0.done, 0);
        check("rst_vec0", if0.vec_out, 0);
        check("rst_err0", if0.err_cnt, 0);
        check("rst_pass0", if0.pass, 0);
        check("rst_ff0", if0.first_fail, 0);
        check("rst_busy1", if1.busy, 0);
        check("rst_err1", if1.err_cnt, 0);
        rst_n = 1'b1;
        @(negedge clk);

        run_sweep("and_s1", 1'b0, 4'b1000, 1, 12, 0, 0, 1'b1, -1);
        run_sweep("or_s1", 1'b0, 4'b1110, 1, OR_DONE, OR_ERR, 1, 1'b0, -1);
        run_sweep("and_s0", 1'b1, 4'b1000, 0, 8, 0, 0, 1'b1, -1);
        run_sweep("nand_s0", 1'b1, 4'b0111, 0, NAND_DONE, NAND_ERR, 0, 1'b0, -1);
        run_sweep("poke_s1", 1'b0, 4'b1000, 1, 12, 0, 0, 1'b1, 5);

        // Reset in the middle of a sweep, then a clean sweep afterwards.
        @(negedge clk);
        sel    = 1'b0;
        tt_drv = 4'b1000;
        start  = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (7) @(negedge clk);
        check("mid_vec", o_vec, 2);
        check("mid_busy", o_busy, 1);
        rst_n = 1'b0;
        #1;
        check("rstmid_vec", o_vec, 0);
        check("rstmid_busy", o_busy, 0);
        check("rstmid_done", o_done, 0);
        check("rstmid_err", o_err, 0);
        check("rstmid_pass", o_pass, 0);
        check("rstmid_ff", o_ff, 0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("rsthold_done", o_done, 0);
        end
        rst_n = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            check("post_rst_idle", o_busy, 0);
            check("post_rst_done", o_done, 0);
        end
        run_sweep("after_rst", 1'b0, 4'b1000, 1, 12, 0, 0, 1'b1, -1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/gate_tt_checker.md
Name: gate_tt_checker

Overview:
- Self-checking stimulus/response stage that wraps a combinational logic gate under test.
- Upstream role: sweeps every input vector onto the gate inputs.
- Downstream role: samples the gate output after a programmable settle time and compares it against a programmable truth table.
- Reports pass/fail, mismatch count and the first failing vector, so gate blocks can be checked in hardware or in a synthesizable bench.

Parameters:
- N_IN, 2, number of gate inputs; sweeps 2**N_IN vectors.
- SETTLE_CYC, 1, idle cycles between driving a vector and sampling y_in (0 allowed).

Ports:
- clk  in  1  single clock; all state updates on its rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  begin a sweep; accepted only in IDLE.
- tt  in  2**N_IN  expected truth table; bit k is the expected y for vector k; latched on start.
- vec_out  out  N_IN  drives the gate inputs; for a 2-input gate, a=vec_out[1], b=vec_out[0].
- y_in  in  1  gate output under test.
- busy  out  1  high from start acceptance until the DONE cycle inclusive.
- done  out  1  one-cycle pulse at sweep end.
- pass  out  1  1 when the last sweep had zero mismatches; held until the next start.
- err_cnt  out  N_IN+1  mismatch count of the current/last sweep; cannot overflow (max 2**N_IN).
- first_fail  out  N_IN  first mismatching vector; valid when err_cnt!=0.

Behaviour:
- Reset (async assert, sync release): state=IDLE; vec_out=0, busy=0, done=0, pass=0, err_cnt=0, first_fail=0, tt_q=0, settle count=0.
- IDLE: busy=0. start=1 latches tt into tt_q, clears err_cnt/first_fail/pass, sets vec=0, goes to DRIVE.
- DRIVE (1 cycle): vec_out=vec. Goes to SETTLE with the counter loaded to SETTLE_CYC-1; goes directly to SAMPLE if SETTLE_CYC==0.
- SETTLE: vec_out held; counts down; goes to SAMPLE when count==0.
- SAMPLE (1 cycle):
  - Compares y_in with tt_q[vec].
  - On mismatch: err_cnt+=1; first_fail=vec if err_cnt was 0.
  - If vec==2**N_IN-1, goes to DONE; else vec+=1 and goes to DRIVE.
  - No wrap: the sweep ends at the all-ones vector.
- DONE (1 cycle): done=1, busy=1; pass registered as (final err_cnt==0); then IDLE. vec_out returns to 0 in IDLE.
- Latency: done is high exactly K*(SETTLE_CYC+2) cycles after the start-accept edge, where K = vectors swept (2**N_IN for a full sweep).
- start while busy: ignored, no restart. tt changes mid-sweep: ignored (tt_q used). start held high continuously: new sweep begins in the cycle after DONE.
- Mismatch counted in the same SAMPLE cycle as the vector's last one; err_cnt is visible the next cycle.
- rst_n asserted mid-sweep: immediate return to reset values; no done pulse.

Optional Feature:
- GATE_TT_CHECKER_STOP_ON_FAIL_EN defined: the first mismatch in SAMPLE goes to DONE instead of the next vector; err_cnt=1, pass=0, K = index of failing vector + 1.
- Undefined: full sweep always; all mismatches counted.

Decomposition:
- Package gate_tt_checker_pkg holds:
  - state encoding localparams: IDLE=0, DRIVE=1, SETTLE=2, SAMPLE=3, DONE=4 (3 bits);
  - default N_IN and SETTLE_CYC.
- One natural sub-module: gate_tt_settle_cnt (loadable down-counter with zero flag), used for SETTLE.

Test Plan:
- N_IN=2, SETTLE_CYC=1, and_gate attached, tt=4'b1000, pulse start -> vec_out steps 00,01,10,11; done 12 cycles after accept; pass=1, err_cnt=0.
- Same bench, tt=4'b1110 (OR table) -> mismatches at vectors 01 and 10; err_cnt=2, first_fail=2'b01, pass=0, done at cycle 12.
- SETTLE_CYC=0, tt=4'b1000 -> done 8 cycles after accept, pass=1.
- Start re-pulsed and tt changed to 4'b0000 at cycle 5 of a tt=4'b1000 sweep -> sweep unaffected; done at cycle 12 with pass=1.
- rst_n low at cycle 6 of a sweep -> all outputs 0 immediately, no done; a new start after release gives a full normal sweep.
- GATE_TT_CHECKER_STOP_ON_FAIL_EN defined, tt=4'b1110 with and_gate -> done 6 cycles after accept; err_cnt=1, first_fail=2'b01, pass=0.
